// File: rtl/drum_pkg.sv
// Shared types and constants for the drum voice scheduler and the mixer top.
// Latency: none (package). Backpressure: none.
// Frequency words are the defaults; the mixer top uses the same values.
package drum_pkg;

    typedef enum logic [1:0] {IDLE, APPLY, SETTLE, RUN} sched_state_t;

    localparam int NUM_PADS = 5;
    localparam logic [NUM_PADS-1:0] SELECT_ALL_OFF = 5'b11111;

    localparam logic [15:0] FREQ_1_DEF = 16'd110;
    localparam logic [15:0] FREQ_2_DEF = 16'd147;
    localparam logic [15:0] FREQ_3_DEF = 16'd196;
    localparam logic [15:0] FREQ_4_DEF = 16'd262;
    localparam logic [15:0] FREQ_5_DEF = 16'd330;

    function automatic logic [2:0] count_ones(input logic [NUM_PADS-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/drum_voice_scheduler_voice_timer.sv
// One voice slot: load arms it with the hold time, clear retires it.
// Latency: 1 cycle from load/clear to active. Backpressure: none.
// The timer keeps counting down in every state; expiry only flags, never self-clears.
module voice_timer #(
    parameter int                 TIMER_W  = 24,
    parameter logic [TIMER_W-1:0] HOLD_VAL = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    output logic active,
    output logic expired
);

    logic [TIMER_W-1:0] timer;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer  <= '0;
            active <= 1'b0;
        end else if (load) begin
            timer  <= HOLD_VAL;
            active <= 1'b1;
        end else begin
            if (clear) begin
                active <= 1'b0;
            end
            if (timer != '0) begin
                timer <= timer - 1'b1;
            end
        end
    end

    assign expired = active && (timer == '0);

endmodule

// File: rtl/drum_voice_scheduler.sv
// Turns pad hits into timed voices driving the mixer select vector; VOICE_RETRIGGER_EN reloads active pads.
// Latency: hit -> select change in 3 cycles from IDLE. Backpressure: none; hits queue in pending until APPLY.
// Select only changes in APPLY and is then held for SETTLE_CYCLES so each mixer pass completes.
module drum_voice_scheduler
    import drum_pkg::*;
#(
    parameter int unsigned  HOLD_CYCLES   = 12_500_000,
    parameter int           TIMER_W       = 24,
    parameter int           SETTLE_CYCLES = 8,
    parameter int           MAX_VOICES    = 5,
    parameter logic [15:0]  FREQ_1        = FREQ_1_DEF,
    parameter logic [15:0]  FREQ_2        = FREQ_2_DEF,
    parameter logic [15:0]  FREQ_3        = FREQ_3_DEF,
    parameter logic [15:0]  FREQ_4        = FREQ_4_DEF,
    parameter logic [15:0]  FREQ_5        = FREQ_5_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_PADS-1:0] pad_hit,
    output logic [NUM_PADS-1:0] select,
    output logic [15:0]         value_1,
    output logic [15:0]         value_2,
    output logic [15:0]         value_3,
    output logic [15:0]         value_4,
    output logic [15:0]         value_5,
    output logic                solo_valid,
    output logic [15:0]         solo_freq,
    output logic                busy,
    output logic [2:0]          voice_count,
    output logic [7:0]          drop_count
);

    localparam logic [TIMER_W-1:0] HOLD_T      = TIMER_W'(HOLD_CYCLES);
    localparam int                 SETTLE_W    = $clog2(SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]         MAX_V       = 3'(MAX_VOICES);

    if (longint'(HOLD_CYCLES) >= (longint'(1) << TIMER_W)) begin : g_bad_hold
        $error("HOLD_CYCLES does not fit in TIMER_W bits");
    end
    if (SETTLE_CYCLES < 8) begin : g_bad_settle
        $error("SETTLE_CYCLES must cover a full mixer pass (>= 8)");
    end
    if (MAX_VOICES < 1 || MAX_VOICES > NUM_PADS) begin : g_bad_max
        $error("MAX_VOICES must be 1..5");
    end

    sched_state_t          state, state_nxt;
    logic [NUM_PADS-1:0]   pending;
    logic [NUM_PADS-1:0]   active, expired;
    logic [NUM_PADS-1:0]   kept, merged, load_vec;
    logic [2:0]            n_voices, n_drops;
    logic [8:0]            drop_sum;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic [15:0]           solo_pick;
    logic                  is_apply;

    assign is_apply = (state == APPLY);

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_voice
        voice_timer #(
            .TIMER_W  (TIMER_W),
            .HOLD_VAL (HOLD_T)
        ) u_timer (
            .clk     (clk),
            .reset   (reset),
            .load    (load_vec[g] & is_apply),
            .clear   (expired[g] & is_apply),
            .active  (active[g]),
            .expired (expired[g])
        );
    end

    // Expired voices go first so their slots are free for this APPLY's merge.
    always_comb begin
        kept     = active & ~expired;
        merged   = kept;
        load_vec = '0;
        n_drops  = '0;
        n_voices = count_ones(kept);
        for (int i = 0; i < NUM_PADS; i++) begin
            if (pending[i]) begin
                if (!kept[i]) begin
                    if (n_voices < MAX_V) begin
                        merged[i]   = 1'b1;
                        load_vec[i] = 1'b1;
                        n_voices    = n_voices + 3'd1;
                    end else begin
                        n_drops = n_drops + 3'd1;
                    end
                end
`ifdef VOICE_RETRIGGER_EN
                else begin
                    load_vec[i] = 1'b1;
                end
`endif
            end
        end
    end

    assign drop_sum = {1'b0, drop_count} + {6'b0, n_drops};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pending != '0) state_nxt = APPLY;
            APPLY:   state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = RUN;
            RUN: begin
                if (pending != '0 || expired != '0) begin
                    state_nxt = APPLY;
                end else if (active == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        solo_pick = '0;
        if (active[0]) solo_pick = solo_pick | FREQ_1;
        if (active[1]) solo_pick = solo_pick | FREQ_2;
        if (active[2]) solo_pick = solo_pick | FREQ_3;
        if (active[3]) solo_pick = solo_pick | FREQ_4;
        if (active[4]) solo_pick = solo_pick | FREQ_5;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= '0;
            select     <= SELECT_ALL_OFF;
            settle_cnt <= '0;
            drop_count <= '0;
            solo_valid <= 1'b0;
            solo_freq  <= '0;
        end else begin
            state <= state_nxt;
            if (is_apply) begin
                // A hit landing on the APPLY cycle survives the pending clear.
                pending    <= pad_hit;
                select     <= ~merged;
                settle_cnt <= '0;
                drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            end else begin
                pending <= pending | pad_hit;
                if (state == SETTLE) begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
            end
            solo_valid <= (state == RUN) && (voice_count == 3'd1);
            solo_freq  <= ((state == RUN) && (voice_count == 3'd1)) ? solo_pick : 16'd0;
        end
    end

    assign voice_count = count_ones(active);
    assign busy        = (state != IDLE);
    assign value_1     = FREQ_1;
    assign value_2     = FREQ_2;
    assign value_3     = FREQ_3;
    assign value_4     = FREQ_4;
    assign value_5     = FREQ_5;

endmodule

// File: tb/tb_drum_voice_scheduler.sv
// Directed table-driven bench for drum_voice_scheduler (HOLD=40, SETTLE=8, MAX_VOICES=3).
module tb_drum_voice_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  pad_hit;
    logic [4:0]  select;
    logic [15:0] value_1, value_2, value_3, value_4, value_5;
    logic        solo_valid;
    logic [15:0] solo_freq;
    logic        busy;
    logic [2:0]  voice_count;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    drum_voice_scheduler #(
        .HOLD_CYCLES   (40),
        .TIMER_W       (24),
        .SETTLE_CYCLES (8),
        .MAX_VOICES    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pad_hit     (pad_hit),
        .select      (select),
        .value_1     (value_1),
        .value_2     (value_2),
        .value_3     (value_3),
        .value_4     (value_4),
        .value_5     (value_5),
        .solo_valid  (solo_valid),
        .solo_freq   (solo_freq),
        .busy        (busy),
        .voice_count (voice_count),
        .drop_count  (drop_count)
    );

    typedef struct {
        logic [4:0]  hit;
        int          steps;
        logic [4:0]  sel;
        logic        solo;
        logic [15:0] freq;
        logic        bsy;
        logic [2:0]  cnt;
        logic [7:0]  drop;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec%0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input int idx, input logic [4:0] s, input logic sv, input logic [15:0] f,
                             input logic b, input logic [2:0] c, input logic [7:0] d);
        chk("select",      idx, {11'd0, select},      {11'd0, s});
        chk("solo_valid",  idx, {15'd0, solo_valid},  {15'd0, sv});
        chk("solo_freq",   idx, solo_freq,            f);
        chk("busy",        idx, {15'd0, busy},        {15'd0, b});
        chk("voice_count", idx, {13'd0, voice_count}, {13'd0, c});
        chk("drop_count",  idx, {8'd0, drop_count},   {8'd0, d});
    endtask

    task automatic apply_vec(input int i);
        pad_hit = tbl[i].hit;
        step(1);
        pad_hit = 5'b0;
        step(tbl[i].steps - 1);
        check_all(i, tbl[i].sel, tbl[i].solo, tbl[i].freq, tbl[i].bsy, tbl[i].cnt, tbl[i].drop);
    endtask

    initial begin
        // Single pad: apply, settle, solo, expiry, back to idle.
        tbl[0]  = '{5'b00001,  2, 5'b11111, 1'b0, 16'd0,   1'b1, 3'd0, 8'd0};
        tbl[1]  = '{5'b00000,  1, 5'b11110, 1'b0, 16'd0,   1'b1, 3'd1, 8'd0};
        tbl[2]  = '{5'b00000,  9, 5'b11110, 1'b1, 16'd110, 1'b1, 3'd1, 8'd0};
        tbl[3]  = '{5'b00000, 33, 5'b11111, 1'b0, 16'd0,   1'b1, 3'd0, 8'd0};
        tbl[4]  = '{5'b00000,  9, 5'b11111, 1'b0, 16'd0,   1'b0, 3'd0, 8'd0};
        // Second pad arriving during SETTLE is held until the next APPLY.
        tbl[5]  = '{5'b00001,  3, 5'b11110, 1'b0, 16'd0,   1'b1, 3'd1, 8'd0};
        tbl[6]  = '{5'b00100,  1, 5'b11110, 1'b0, 16'd0,   1'b1, 3'd1, 8'd0};
        tbl[7]  = '{5'b00000,  8, 5'b11110, 1'b1, 16'd110, 1'b1, 3'd1, 8'd0};
        tbl[8]  = '{5'b00000,  1, 5'b11010, 1'b0, 16'd0,   1'b1, 3'd2, 8'd0};
        tbl[9]  = '{5'b00000, 32, 5'b11011, 1'b0, 16'd0,   1'b1, 3'd1, 8'd0};
        tbl[10] = '{5'b00000,  9, 5'b11011, 1'b1, 16'd196, 1'b1, 3'd1, 8'd0};
        tbl[11] = '{5'b00000, 10, 5'b11111, 1'b0, 16'd0,   1'b0, 3'd0, 8'd0};
        // All five pads at once against a limit of three.
        tbl[12] = '{5'b11111,  3, 5'b11000, 1'b0, 16'd0,   1'b1, 3'd3, 8'd2};
        // Re-hit of pad 2 twenty cycles after the first hit.
        tbl[13] = '{5'b00010,  3, 5'b11101, 1'b0, 16'd0,   1'b1, 3'd1, 8'd0};
        tbl[14] = '{5'b00000, 17, 5'b11101, 1'b1, 16'd147, 1'b1, 3'd1, 8'd0};
        tbl[15] = '{5'b00010,  3, 5'b11101, 1'b0, 16'd0,   1'b1, 3'd1, 8'd0};
`ifdef VOICE_RETRIGGER_EN
        tbl[16] = '{5'b00000, 22, 5'b11101, 1'b1, 16'd147, 1'b1, 3'd1, 8'd0};
`else
        tbl[16] = '{5'b00000, 22, 5'b11111, 1'b0, 16'd0,   1'b1, 3'd0, 8'd0};
`endif
        tbl[17] = '{5'b00000, 30, 5'b11111, 1'b0, 16'd0,   1'b0, 3'd0, 8'd0};

        reset   = 1'b1;
        pad_hit = 5'b0;
        step(2);
        check_all(-1, 5'b11111, 1'b0, 16'd0, 1'b0, 3'd0, 8'd0);
        chk("value_1", -1, value_1, 16'd110);
        chk("value_2", -1, value_2, 16'd147);
        chk("value_3", -1, value_3, 16'd196);
        chk("value_4", -1, value_4, 16'd262);
        chk("value_5", -1, value_5, 16'd330);
        reset = 1'b0;

        for (int i = 0; i <= 12; i++) begin
            apply_vec(i);
        end

        // Reset in SETTLE with three voices; the hit on the reset cycle must be discarded.
        reset   = 1'b1;
        pad_hit = 5'b00010;
        step(1);
        check_all(100, 5'b11111, 1'b0, 16'd0, 1'b0, 3'd0, 8'd0);
        reset   = 1'b0;
        pad_hit = 5'b0;
        step(3);
        check_all(101, 5'b11111, 1'b0, 16'd0, 1'b0, 3'd0, 8'd0);

        for (int i = 13; i < NVEC; i++) begin
            apply_vec(i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/drum_voice_scheduler.md
Name: drum_voice_scheduler

Overview:
- Sequences the five-input frequency mixer. Converts drum-pad hit pulses into timed voices and drives the mixer's active-low select vector and per-voice frequency words.
- Holds select stable long enough for each mixer averaging pass to complete.
- The mixer produces no output for single-voice patterns, so this block provides a solo bypass for the top level to mux.

Parameters:
- HOLD_CYCLES, 24'd12_500_000, voice duration in clk cycles (250 ms at 50 MHz).
- TIMER_W, 24, per-voice timer width.
- SETTLE_CYCLES, 8, minimum select dwell after any change; must be ≥ 8 (mixer pass length).
- MAX_VOICES, 5, maximum simultaneous voices (1..5).
- FREQ_1..FREQ_5, 16'd110/16'd147/16'd196/16'd262/16'd330, pad frequency words.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pad_hit  in  5  one-cycle hit pulse per pad (bit i = pad i+1)
- select  out  5  to mixer, active-low voice enable, registered
- value_1..value_5  out  16 each  to mixer, FREQ_n constants
- solo_valid  out  1  exactly one voice active and select settled
- solo_freq  out  16  frequency of the solo voice, else 0
- busy  out  1  state != IDLE
- voice_count  out  3  number of active voices
- drop_count  out  8  hits dropped by the voice limit, saturating at 255

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: select = 5'b11111; solo_valid = 0; solo_freq = 0; busy = 0; voice_count = 0; drop_count = 0; all timers 0; pending = 0; state = IDLE.
- Reset mid-operation has the same effect, and the in-flight hit on that cycle is discarded.
- pending[4:0] |= pad_hit every cycle, in every state except APPLY. In APPLY, a same-cycle hit is ORed into the post-clear pending, so it is never lost.
- Timers: each active voice's timer decrements by 1 per cycle while nonzero, in all states. A voice is expired when active and timer == 0. Expired voices stay in select until the next APPLY; select changes only in APPLY.
- IDLE: select = 11111. If pending != 0, go to APPLY.
- APPLY (1 cycle), in this order:
  - Remove expired voices.
  - Merge pending bits, lowest index first. New pads load timer = HOLD_CYCLES.
  - When active count reaches MAX_VOICES, remaining new pads are dropped; drop_count += 1 per dropped pad.
  - Clear pending; register select = ~active.
  - Go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to RUN. A settle counter value of SETTLE_CYCLES-1 means done.
- RUN:
  - If pending != 0 or any voice has expired, go to APPLY.
  - Else if active == 0, go to IDLE.
  - Else stay in RUN.
  - An all-expired APPLY yields select = 11111, then SETTLE, then RUN, then IDLE.
- Hit on an already-active pad is handled per the optional feature.
- solo_valid = 1 only in RUN with voice_count == 1; solo_freq = that pad's FREQ_n. Both are registered, one cycle after RUN entry. solo_valid = 0 in SETTLE.
- Simultaneous hits on all 5 pads with MAX_VOICES = 3: pads 1–3 accepted, 4–5 dropped, drop_count += 2.
- Timer width: HOLD_CYCLES must fit in TIMER_W; elaboration error otherwise.

Optional Feature:
- Macro: VOICE_RETRIGGER_EN.
- Defined: a hit on an active, unexpired pad reloads that pad's timer to HOLD_CYCLES in APPLY. It consumes no new voice slot, is never dropped, and select is unchanged.
- Undefined: such a hit is ignored; its pending bit is cleared in APPLY and drop_count is unchanged.

Decomposition:
- Shared package drum_pkg:
  - sched_state_t enum {IDLE, APPLY, SETTLE, RUN} (logic [1:0]).
  - NUM_PADS = 5.
  - SELECT_ALL_OFF = 5'b11111.
  - Default FREQ_n constants, also used by the mixer top.
- One natural sub-module: voice_timer (load, decrement, expired flag), instantiated 5 times via generate.

Test Plan:
- HOLD_CYCLES=40, SETTLE_CYCLES=8: pad_hit=00001 → select=11110 one cycle after APPLY; solo_valid=1, solo_freq=110 in RUN; select back to 11111 and busy=0 about 51 cycles later.
- Hits on pad 1 at t0 and pad 3 at t0+3 (during SETTLE) → select=11110, held 8 cycles, then 11010; solo_valid falls after the second APPLY.
- MAX_VOICES=3, pad_hit=11111 in one cycle → select=11000, voice_count=3, drop_count=2.
- Pad 2 hit, then re-hit at t+20 with HOLD_CYCLES=40:
  - Macro defined → release at about t+60.
  - Macro undefined → release at about t+40, drop_count=0 in both cases.
- reset asserted in SETTLE with 3 voices active → next cycle select=11111, voice_count=0, busy=0; a pad_hit on the reset cycle is not accepted.
